// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use hold, redirect bubbles, IRQ/exception
// qualification and EPC capture. Define IFID_PERF_CNT_EN for saturating stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          KBIT     = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_Instruction,
    input  logic        Loaduse,
    input  logic        EX_Branch_EN,
    input  logic        ID_Jump_I,
    input  logic        ID_Jump_R,
    input  logic        ID_Undef,
    input  logic        IRQ_in,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC_Plus_4,
    output logic [31:0] ID_Instruction,
    output logic        ID_Valid,
    output logic        ID_IRQ,
    output logic        ID_EXP,
    output logic [31:0] ID_EPC
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Cnt,
    output logic [31:0] Flush_Cnt
`endif
);
    logic [31:0] pc_q, pc_d, instr_q, instr_d, epc_q, epc_d;
    logic        valid_q, valid_d, irq_m_q, irq_s_q, flush;

    assign ID_PC          = pc_q;
    assign ID_PC_Plus_4   = pc_q + 32'd4;
    assign ID_Instruction = instr_q;
    assign ID_Valid       = valid_q;
    assign ID_EPC         = epc_q;
    // bubbles and kernel-mode code never take traps
    assign ID_IRQ = irq_s_q & valid_q & ~pc_q[KBIT];
    assign ID_EXP = ID_Undef & valid_q & ~pc_q[KBIT] & ~ID_IRQ;
    assign flush  = ID_IRQ | ID_EXP | EX_Branch_EN | ID_Jump_I | ID_Jump_R;

    always_comb begin
        pc_d    = (flush | ~Loaduse) ? IF_PC : pc_q;
        instr_d = flush ? NOP : (Loaduse ? instr_q : IF_Instruction);
        valid_d = ~flush & (Loaduse ? valid_q : 1'b1);
        epc_d   = ID_IRQ ? pc_q : (ID_EXP ? ID_PC_Plus_4 : epc_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
            epc_q   <= 32'd0;
            irq_m_q <= 1'b0;
            irq_s_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
            irq_m_q <= IRQ_in;
            irq_s_q <= irq_m_q;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q     <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (~flush & Loaduse & ~&stall_q) stall_q <= stall_q + 32'd1;
            if (flush & ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign Stall_Cnt = stall_q;
    assign Flush_Cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed literal checks plus randomized run against a behavioural IF/ID model.
module tb_if_id_stage;
    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] IF_PC = 0, IF_Instruction = 0;
    logic        Loaduse = 0, EX_Branch_EN = 0, ID_Jump_I = 0, ID_Jump_R = 0, ID_Undef = 0, IRQ_in = 0;
    logic [31:0] ID_PC, ID_PC_Plus_4, ID_Instruction, ID_EPC;
    logic        ID_Valid, ID_IRQ, ID_EXP;
    int          vecs = 0, errs = 0;

    if_id_stage dut (
        .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_Instruction(IF_Instruction),
        .Loaduse(Loaduse), .EX_Branch_EN(EX_Branch_EN), .ID_Jump_I(ID_Jump_I),
        .ID_Jump_R(ID_Jump_R), .ID_Undef(ID_Undef), .IRQ_in(IRQ_in),
        .ID_PC(ID_PC), .ID_PC_Plus_4(ID_PC_Plus_4), .ID_Instruction(ID_Instruction),
        .ID_Valid(ID_Valid), .ID_IRQ(ID_IRQ), .ID_EXP(ID_EXP), .ID_EPC(ID_EPC)
`ifdef IFID_PERF_CNT_EN
        , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

`ifdef IFID_PERF_CNT_EN
    logic [31:0] Stall_Cnt, Flush_Cnt;
    logic [31:0] m_stall, m_flush;
`endif

    always #5 clk = ~clk;

    // model: ID slot contents plus the IRQ_in samples of the last two edges
    logic [31:0] m_pc, m_ins, m_epc;
    logic        m_val;
    logic [1:0]  irq_hist;
    wire  m_irq = irq_hist[1] & m_val & ~m_pc[31];
    wire  m_exp = ID_Undef & m_val & ~m_pc[31] & ~m_irq;
    wire  m_redirect = m_irq | m_exp | EX_Branch_EN | ID_Jump_I | ID_Jump_R;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 0; m_ins <= 0; m_val <= 0; m_epc <= 0; irq_hist <= 0;
`ifdef IFID_PERF_CNT_EN
            m_stall <= 0; m_flush <= 0;
`endif
        end else begin
            irq_hist <= {irq_hist[0], IRQ_in};
            if (m_redirect) begin
                m_pc <= IF_PC; m_ins <= 0; m_val <= 0;
            end else if (!Loaduse) begin
                m_pc <= IF_PC; m_ins <= IF_Instruction; m_val <= 1;
            end
            if (m_irq) m_epc <= m_pc;
            else if (m_exp) m_epc <= m_pc + 32'd4;
`ifdef IFID_PERF_CNT_EN
            if (m_redirect && m_flush != 32'hFFFF_FFFF) m_flush <= m_flush + 1;
            if (!m_redirect && Loaduse && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 1;
`endif
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        chk("pc", ID_PC, m_pc);
        chk("pc4", ID_PC_Plus_4, m_pc + 32'd4);
        chk("instr", ID_Instruction, m_ins);
        chk("valid", {31'd0, ID_Valid}, {31'd0, m_val});
        chk("irq", {31'd0, ID_IRQ}, {31'd0, m_irq});
        chk("exp", {31'd0, ID_EXP}, {31'd0, m_exp});
        chk("epc", ID_EPC, m_epc);
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt", Stall_Cnt, m_stall);
        chk("flush_cnt", Flush_Cnt, m_flush);
`endif
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                         input bit lu, input bit br, input bit und, input bit irq);
        @(negedge clk);
        IF_PC = pc; IF_Instruction = ins; Loaduse = lu; EX_Branch_EN = br;
        ID_Jump_I = 0; ID_Jump_R = 0; ID_Undef = und; IRQ_in = irq;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string n, input logic [31:0] pc, input logic [31:0] ins, input bit v);
        chk({n, ".pc"}, ID_PC, pc);
        chk({n, ".instr"}, ID_Instruction, ins);
        chk({n, ".valid"}, {31'd0, ID_Valid}, {31'd0, v});
    endtask

    initial begin
        #1 reset = 1;
        #1 chk_id("rst", 32'h0, 32'h0, 0);
        chk("rst.epc", ID_EPC, 32'h0);
        @(negedge clk) reset = 0;
        // free run
        drive(32'h0, 32'hA, 0, 0, 0, 0); tick; chk_id("ld0", 32'h0, 32'hA, 1); chk("ld0.pc4", ID_PC_Plus_4, 32'h4);
        drive(32'h4, 32'hB, 0, 0, 0, 0); tick; chk_id("ld1", 32'h4, 32'hB, 1); chk("ld1.pc4", ID_PC_Plus_4, 32'h8);
        // two-cycle load-use hold
        drive(32'h8, 32'hC, 1, 0, 0, 0); tick; chk_id("hold1", 32'h4, 32'hB, 1);
        drive(32'h8, 32'hC, 1, 0, 0, 0); tick; chk_id("hold2", 32'h4, 32'hB, 1);
        drive(32'h8, 32'hC, 0, 0, 0, 0); tick; chk_id("ld2", 32'h8, 32'hC, 1); chk("ld2.pc4", ID_PC_Plus_4, 32'hC);
        // branch beats loaduse; bubble blocks a synchronized IRQ
        drive(32'hC, 32'hD, 1, 1, 0, 1); tick; chk_id("br1", 32'hC, 32'h0, 0);
        drive(32'h8, 32'hD, 1, 1, 0, 1); tick; chk_id("br2", 32'h8, 32'h0, 0); chk("br2.irq", {31'd0, ID_IRQ}, 0);
        drive(32'h3C, 32'h0, 0, 1, 0, 0); tick;
        drive(32'h3C, 32'h0, 0, 1, 0, 0); tick;
        // interrupt: two-flop latency, EPC = interrupted PC
        drive(32'h40, 32'h1234_5678, 0, 0, 0, 1); tick; chk_id("irq0", 32'h40, 32'h1234_5678, 1); chk("irq0.irq", {31'd0, ID_IRQ}, 0);
        drive(32'h44, 32'h5, 1, 0, 0, 1); tick; chk("irq1.irq", {31'd0, ID_IRQ}, 1); chk("irq1.pc", ID_PC, 32'h40);
        drive(32'h44, 32'h5, 0, 0, 0, 0); tick; chk("irq2.epc", ID_EPC, 32'h40); chk_id("irq2", 32'h44, 32'h0, 0);
        // undefined instruction with loaduse high: EPC = PC + 4
        drive(32'h100, 32'hDD, 0, 0, 0, 0); tick; chk_id("ldu", 32'h100, 32'hDD, 1); chk("ldu.irq", {31'd0, ID_IRQ}, 0);
        drive(32'h104, 32'hEE, 1, 0, 1, 0); #1 chk("exp.exp", {31'd0, ID_EXP}, 1);
        tick; chk("exp.epc", ID_EPC, 32'h104); chk("exp.valid", {31'd0, ID_Valid}, 0);
        // kernel mode masks the exception
        drive(32'h8000_0100, 32'hEE, 0, 0, 0, 0); tick;
        drive(32'h8000_0104, 32'hFF, 1, 0, 1, 0); #1 chk("kexp.exp", {31'd0, ID_EXP}, 0);
        tick; chk("kexp.epc", ID_EPC, 32'h104); chk_id("kexp", 32'h8000_0100, 32'hEE, 1);
        // asynchronous reset during hold
        drive(32'h20, 32'h77, 0, 0, 0, 0); tick;
        drive(32'h24, 32'h88, 1, 0, 0, 0); tick; chk_id("pre_rst", 32'h20, 32'h77, 1);
        #1 reset = 1;
        #1 chk_id("arst", 32'h0, 32'h0, 0); chk("arst.epc", ID_EPC, 32'h0);
        @(negedge clk) reset = 0;
        // PC + 4 wraps
        drive(32'hFFFF_FFFC, 32'h99, 0, 0, 0, 0); tick; chk("wrap.pc4", ID_PC_Plus_4, 32'h0);
        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            IF_PC = {($urandom_range(0, 3) == 0), 23'd0, 6'($urandom), 2'b00};
            if ($urandom_range(0, 49) == 0) IF_PC = 32'hFFFF_FFFC;
            IF_Instruction = $urandom;
            Loaduse = ($urandom_range(0, 3) == 0);
            EX_Branch_EN = ($urandom_range(0, 9) == 0);
            ID_Jump_I = ($urandom_range(0, 19) == 0);
            ID_Jump_R = ($urandom_range(0, 19) == 0);
            ID_Undef = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) IRQ_in = ~IRQ_in;
        end
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
